// File: rtl/tsp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tsp_ctrl_pkg
// Shared types and constants for the TSP run controller:
//   state_t  - run-controller FSM states
//   LED_*    - bit positions inside the LEDR status vector
// -----------------------------------------------------------------------------
package tsp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam int LED_RUN = 0;  // START or RUN
  localparam int LED_FIN = 1;  // DONE
  localparam int LED_TO  = 2;  // sticky watchdog timeout
  localparam int LED_IMP = 3;  // toggles on every best-cost improvement

endpackage

// File: rtl/tsp_run_ctrl_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a bus of quasi-static signals (switches).
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, both stages clear to 0
//   d     - asynchronous input bus
//   q     - synchronized output bus
// -----------------------------------------------------------------------------
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; only q is consumed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= {WIDTH{1'b0}};
      q    <= {WIDTH{1'b0}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tsp_run_ctrl.sv
// -----------------------------------------------------------------------------
// tsp_run_ctrl
// Run controller for the TSP solver core. Starts the core once per iteration
// for MAX_ITER iterations, keeps the best tour cost, aborts on a hung core
// (watchdog) or on an instance-switch change, and drives LEDR status.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   SW          - instance select (asynchronous, synchronized internally)
//   core_ready  - core idle / can accept a start
//   core_done   - one-cycle iteration-finished pulse, core_cost valid with it
//   core_start  - one-cycle start pulse to the core
//   core_inst   - instance latched for the current run
//   core_abort  - one-cycle abort pulse to the core
//   best_cost   - minimum cost of this run (all-ones = none yet)
//   iter_cnt    - completed iterations of this run
//   LEDR        - [0] running, [1] finished, [2] timeout, [3] improvement toggle
// -----------------------------------------------------------------------------
module tsp_run_ctrl
  import tsp_ctrl_pkg::*;
#(
  parameter int SW_W     = 2,
  parameter int COST_W   = 20,
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 1000,
  parameter int TO_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   SW,
  input  logic              core_ready,
  input  logic              core_done,
  input  logic [COST_W-1:0] core_cost,
  output logic              core_start,
  output logic [SW_W-1:0]   core_inst,
  output logic              core_abort,
  output logic [COST_W-1:0] best_cost,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [3:0]        LEDR
);

  localparam logic [ITER_W-1:0] MAX_ITER_V = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_ONE   = {{(ITER_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]   WD_ONE     = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]   WD_MAX     = {TO_W{1'b1}};
  localparam logic [COST_W-1:0] COST_NONE  = {COST_W{1'b1}};

  logic [SW_W-1:0]   sw_s;
  state_t            state, state_nx;
  logic [TO_W-1:0]   wd, wd_nx, wd_inc;
  logic [ITER_W-1:0] iter_nx, iter_inc;
  logic [SW_W-1:0]   inst_nx;
  logic [COST_W-1:0] best_nx;
  logic              wait_rdy, wait_nx;    // counted done seen, waiting for core_ready
  logic              to_abort, to_abort_nx; // current ABORT was caused by the watchdog
  logic              led_to, led_to_nx;
  logic              led_imp, led_imp_nx;
  logic              sw_change;

  sync2 #(.WIDTH(SW_W)) u_sw_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (SW),
    .q     (sw_s)
  );

  assign sw_change = (sw_s != core_inst);
  assign wd_inc    = wd + WD_ONE;
  assign iter_inc  = iter_cnt + ITER_ONE;

  // Next-state and next-value logic for the FSM, counters and cost register.
  always_comb begin
    state_nx    = state;
    inst_nx     = core_inst;
    best_nx     = best_cost;
    iter_nx     = iter_cnt;
    wd_nx       = wd;
    wait_nx     = wait_rdy;
    to_abort_nx = to_abort;
    led_to_nx   = led_to;
    led_imp_nx  = led_imp;
    case (state)
      IDLE: begin
        if (core_ready) begin
          inst_nx   = sw_s;
          best_nx   = COST_NONE;
          iter_nx   = {ITER_W{1'b0}};
          led_to_nx = 1'b0;
          state_nx  = START;
        end else begin
          state_nx  = IDLE;
        end
      end
      START: begin
        wd_nx       = {TO_W{1'b0}};
        wait_nx     = 1'b0;
        to_abort_nx = 1'b0;
        state_nx    = RUN;
      end
      RUN: begin
        wd_nx = wd_inc;
        if (core_done) begin
          // The iteration is counted and its cost kept even if we abort now.
          iter_nx = iter_inc;
          wd_nx   = {TO_W{1'b0}};
          wait_nx = 1'b0;
          if (core_cost < best_cost) begin
            best_nx    = core_cost;
            led_imp_nx = ~led_imp;
          end else begin
            best_nx    = best_cost;
          end
          if (sw_change) begin
            state_nx = ABORT;
          end else if (iter_inc == MAX_ITER_V) begin
            state_nx = DONE;
          end else if (core_ready) begin
            state_nx = START;
          end else begin
            state_nx = RUN;
            wait_nx  = 1'b1;
          end
        end else if (sw_change) begin
          state_nx = ABORT;
        end else if (wd_inc == WD_MAX) begin
          // Expiry is judged on the incremented value so RUN lasts 2^TO_W-1 cycles.
          led_to_nx   = 1'b1;
          to_abort_nx = 1'b1;
          state_nx    = ABORT;
        end else if (wait_rdy && core_ready) begin
          state_nx = START;
        end else begin
          state_nx = RUN;
        end
      end
      ABORT: begin
        if (to_abort) begin
          state_nx = DONE;
        end else begin
          state_nx = IDLE;
        end
      end
      DONE: begin
        if (sw_change) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      core_inst <= {SW_W{1'b0}};
      best_cost <= COST_NONE;
      iter_cnt  <= {ITER_W{1'b0}};
      wd        <= {TO_W{1'b0}};
      wait_rdy  <= 1'b0;
      to_abort  <= 1'b0;
      led_to    <= 1'b0;
      led_imp   <= 1'b0;
    end else begin
      state     <= state_nx;
      core_inst <= inst_nx;
      best_cost <= best_nx;
      iter_cnt  <= iter_nx;
      wd        <= wd_nx;
      wait_rdy  <= wait_nx;
      to_abort  <= to_abort_nx;
      led_to    <= led_to_nx;
      led_imp   <= led_imp_nx;
    end
  end

  // Pulses and status decoded from registered state only.
  always_comb begin
    core_start       = (state == START);
    core_abort       = (state == ABORT);
    LEDR             = 4'b0000;
    LEDR[LED_RUN]    = (state == START) || (state == RUN);
    LEDR[LED_FIN]    = (state == DONE);
    LEDR[LED_TO]     = led_to;
    LEDR[LED_IMP]    = led_imp;
  end

endmodule

// File: tb/tb_tsp_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tsp_run_ctrl
// Self-checking bench for tsp_run_ctrl with MAX_ITER=4, TO_W=4.
// -----------------------------------------------------------------------------
module tb_tsp_run_ctrl;

  localparam logic [19:0] NONE = 20'hFFFFF;

  logic        clk;
  logic        rst;
  logic [1:0]  SW;
  logic        core_ready;
  logic        core_done;
  logic [19:0] core_cost;
  logic        core_start;
  logic [1:0]  core_inst;
  logic        core_abort;
  logic [19:0] best_cost;
  logic [15:0] iter_cnt;
  logic [3:0]  LEDR;

  int n_tests = 0;
  int n_fail  = 0;

  tsp_run_ctrl #(
    .SW_W(2), .COST_W(20), .ITER_W(16), .MAX_ITER(4), .TO_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SW         (SW),
    .core_ready (core_ready),
    .core_done  (core_done),
    .core_cost  (core_cost),
    .core_start (core_start),
    .core_inst  (core_inst),
    .core_abort (core_abort),
    .best_cost  (best_cost),
    .iter_cnt   (iter_cnt),
    .LEDR       (LEDR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sw;
    logic        rdy;
    logic        done;
    logic [19:0] cost;
    logic        start;
    logic        abort;
    logic [1:0]  inst;
    logic [15:0] iter;
    logic [19:0] best;
    logic [3:0]  ledr;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_start(input int budget, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!core_start && n < budget);
    chk(name, {63'd0, core_start}, 64'd1);
  endtask

  task automatic cycles_to_abort(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!core_abort && n < budget);
  endtask

  function automatic logic [43:0] outs();
    return {core_start, core_abort, core_inst, iter_cnt, best_cost, LEDR};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [0:12];
    int n, v, prev, lat, rlow, nimp;
    int lead_toggles;
    logic led3_0, led3_prev;
    logic [19:0] c, mn;
    logic [19:0] costs [$];

    //              sw    rdy   done  cost     start abort inst  iter   best      ledr
    tbl[0]  = '{2'd1, 1'b0, 1'b0, 20'd0,   1'b0, 1'b0, 2'd0, 16'd0, NONE,     4'b0000};
    tbl[1]  = '{2'd1, 1'b0, 1'b0, 20'd0,   1'b0, 1'b0, 2'd0, 16'd0, NONE,     4'b0000};
    tbl[2]  = '{2'd1, 1'b1, 1'b0, 20'd0,   1'b1, 1'b0, 2'd1, 16'd0, NONE,     4'b0001};
    tbl[3]  = '{2'd1, 1'b1, 1'b0, 20'd0,   1'b0, 1'b0, 2'd1, 16'd0, NONE,     4'b0001};
    tbl[4]  = '{2'd1, 1'b1, 1'b1, 20'd500, 1'b1, 1'b0, 2'd1, 16'd1, 20'd500,  4'b1001};
    tbl[5]  = '{2'd1, 1'b1, 1'b0, 20'd0,   1'b0, 1'b0, 2'd1, 16'd1, 20'd500,  4'b1001};
    tbl[6]  = '{2'd1, 1'b1, 1'b1, 20'd300, 1'b1, 1'b0, 2'd1, 16'd2, 20'd300,  4'b0001};
    tbl[7]  = '{2'd1, 1'b1, 1'b0, 20'd0,   1'b0, 1'b0, 2'd1, 16'd2, 20'd300,  4'b0001};
    tbl[8]  = '{2'd1, 1'b1, 1'b1, 20'd300, 1'b1, 1'b0, 2'd1, 16'd3, 20'd300,  4'b0001};
    tbl[9]  = '{2'd1, 1'b1, 1'b0, 20'd0,   1'b0, 1'b0, 2'd1, 16'd3, 20'd300,  4'b0001};
    tbl[10] = '{2'd1, 1'b1, 1'b1, 20'd700, 1'b0, 1'b0, 2'd1, 16'd4, 20'd300,  4'b0010};
    tbl[11] = '{2'd1, 1'b1, 1'b1, 20'd1,   1'b0, 1'b0, 2'd1, 16'd4, 20'd300,  4'b0010};
    tbl[12] = '{2'd1, 1'b1, 1'b0, 20'd0,   1'b0, 1'b0, 2'd1, 16'd4, 20'd300,  4'b0010};

    rst = 1'b0; SW = 2'd1; core_ready = 1'b0; core_done = 1'b0; core_cost = 20'd0;
    #11;
    chk("reset_values", {20'd0, outs()}, {20'd0, 1'b0, 1'b0, 2'd0, 16'd0, NONE, 4'b0000});
    #1 rst = 1'b1;

    // Full run: costs 500, 300, 300, 700; then a done while finished is ignored.
    lead_toggles = 0;
    led3_prev = LEDR[3];
    for (int i = 0; i <= 12; i++) begin
      SW = tbl[i].sw; core_ready = tbl[i].rdy; core_done = tbl[i].done; core_cost = tbl[i].cost;
      step();
      chk($sformatf("table_row%0d", i), {20'd0, outs()},
          {20'd0, tbl[i].start, tbl[i].abort, tbl[i].inst, tbl[i].iter, tbl[i].best, tbl[i].ledr});
      if (LEDR[3] != led3_prev) lead_toggles++;
      led3_prev = LEDR[3];
    end
    core_done = 1'b0;
    chk("improve_toggles", 64'(lead_toggles), 64'd2);

    // Hung core: abort 15 cycles after entering RUN, then DONE with timeout LED.
    SW = 2'd2;
    wait_start(10, "hang_start");
    chk("hang_inst", {62'd0, core_inst}, 64'd2);
    cycles_to_abort(30, n);
    chk("hang_abort_latency", 64'(n), 64'd16);
    step();
    chk("hang_done_status", {20'd0, outs()}, {20'd0, 1'b0, 1'b0, 2'd2, 16'd0, NONE, 4'b0110});

    // Switch change during iteration 2 restarts with the new instance.
    SW = 2'd0;
    wait_start(10, "sw_run_start");
    step();
    core_done = 1'b1; core_cost = 20'd50;
    step();
    core_done = 1'b0;
    chk("sw_iter1", {20'd0, outs()}, {20'd0, 1'b1, 1'b0, 2'd0, 16'd1, 20'd50, 4'b1001});
    step();
    SW = 2'd3;
    cycles_to_abort(10, n);
    chk("sw_abort_latency", 64'(n), 64'd3);
    wait_start(10, "sw_restart");
    chk("sw_restart_state", {30'd0, core_inst, iter_cnt, best_cost}, {30'd0, 2'd3, 16'd0, NONE});

    // core_done in the same cycle the switch change is acted on.
    step();
    SW = 2'd1;
    step();
    step();
    core_done = 1'b1; core_cost = 20'd100;
    step();
    core_done = 1'b0;
    chk("done_with_change", {20'd0, outs()}, {20'd0, 1'b0, 1'b1, 2'd3, 16'd1, 20'd100, 4'b0000});

    // core_ready low for 5 cycles after core_done.
    wait_start(10, "rdy_run_start");
    chk("rdy_inst", {62'd0, core_inst}, 64'd1);
    step();
    core_done = 1'b1; core_cost = 20'd40; core_ready = 1'b0;
    step();
    core_done = 1'b0;
    chk("rdy_after_done", {20'd0, outs()}, {20'd0, 1'b0, 1'b0, 2'd1, 16'd1, 20'd40, 4'b1001});
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rdy_low_hold%0d", k), {62'd0, core_start, core_abort}, 64'd0);
    end
    core_ready = 1'b1;
    step();
    chk("rdy_rise_start", {62'd0, core_start, core_abort}, 64'd2);

    // Asynchronous reset in RUN with iter_cnt = 2.
    step();
    core_done = 1'b1; core_cost = 20'd60;
    step();
    core_done = 1'b0;
    step();
    chk("pre_reset_run", {47'd0, iter_cnt, LEDR[0]}, {47'd0, 16'd2, 1'b1});
    #2 rst = 1'b0;
    #1;
    chk("async_reset", {20'd0, outs()}, {20'd0, 1'b0, 1'b0, 2'd0, 16'd0, NONE, 4'b0000});
    core_ready = 1'b0;
    v = $urandom_range(0, 3);
    SW = v[1:0];
    #2 rst = 1'b1;
    repeat (3) step();
    core_ready = 1'b1;

    // Randomized runs against a scoreboard: best = minimum of returned costs,
    // LEDR[3] flips once per strict new minimum, iterations counted up to 4.
    prev = v;
    for (int run = 0; run < 6; run++) begin
      if (run > 0) begin
        do v = $urandom_range(0, 3); while (v == prev);
        SW = v[1:0];
      end
      wait_start(12, $sformatf("rnd%0d_start", run));
      chk($sformatf("rnd%0d_begin", run), {30'd0, core_inst, iter_cnt, best_cost},
          {30'd0, v[1:0], 16'd0, NONE});
      led3_0 = LEDR[3];
      costs.delete();
      nimp = 0;
      for (int it = 1; it <= 4; it++) begin
        lat = $urandom_range(1, 4);
        repeat (lat) begin
          step();
          chk("rnd_busy", {62'd0, core_start, core_abort}, 64'd0);
        end
        c = 20'($urandom_range(0, 7) * 100);
        rlow = (it == 4) ? 0 : $urandom_range(0, 3);
        mn = NONE;
        foreach (costs[j]) if (costs[j] < mn) mn = costs[j];
        if (c < mn) nimp++;
        costs.push_back(c);
        if (c < mn) mn = c;
        core_done = 1'b1; core_cost = c; core_ready = (rlow == 0);
        step();
        core_done = 1'b0;
        chk($sformatf("rnd%0d_it%0d", run, it), {27'd0, iter_cnt, best_cost, LEDR[3]},
            {27'd0, 16'(it), mn, led3_0 ^ nimp[0]});
        if (it == 4) begin
          chk("rnd_finished", {62'd0, LEDR[1], core_start}, 64'd2);
        end else if (rlow == 0) begin
          chk("rnd_next_start", {63'd0, core_start}, 64'd1);
        end else begin
          chk("rnd_wait_nostart", {63'd0, core_start}, 64'd0);
          repeat (rlow) begin
            step();
            chk("rnd_wait_nostart", {62'd0, core_start, core_abort}, 64'd0);
          end
          core_ready = 1'b1;
          step();
          chk("rnd_ready_start", {63'd0, core_start}, 64'd1);
        end
      end
      prev = v;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
